rv32_div: RTL and testbench

RV32_DIV -- requirements
Module: rv32_div

---
 rtl/rv32_div.sv | 131 +++++++++++++
 tb/tb_rv32_div.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_div.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) using restoring division on operand magnitudes.
// Signs are reapplied in FIXUP; divide-by-zero and signed overflow bypass the iteration loop.
//
// state | meaning
// IDLE  | waiting for start_in
// CALC  | 32 restoring-division steps, one per non-stalled edge
// FIXUP | sign correction / special-case select, registers result_out
// DONE  | result valid, done_out high
module rv32_div (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        start_in,
    input  logic [1:0]  op_in,
    input  logic [31:0] rs1_value_in,
    input  logic [31:0] rs2_value_in,
    output logic        busy_out,
    output logic        done_out,
    output logic [31:0] result_out
);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [1:0]  op_r;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [32:0] rem;
    logic        neg_q, neg_r, div0, ovf;

    logic        signed_op, a_neg, b_neg, in_div0, in_ovf, in_special, accept;
    logic [31:0] a_mag, b_mag;
    logic [32:0] rem_sh, diff;
    logic        q_bit;
    logic [31:0] fix_result;

    always_comb begin
        signed_op  = ~op_in[0];
        a_neg      = signed_op & rs1_value_in[31];
        b_neg      = signed_op & rs2_value_in[31];
        a_mag      = a_neg ? (32'd0 - rs1_value_in) : rs1_value_in;
        b_mag      = b_neg ? (32'd0 - rs2_value_in) : rs2_value_in;
        in_div0    = (rs2_value_in == 32'd0);
        in_ovf     = signed_op && (rs1_value_in == 32'h8000_0000) && (rs2_value_in == 32'hFFFF_FFFF);
        in_special = in_div0 | in_ovf;
        accept     = (state == IDLE) && start_in && !stall_in;
    end

    // dvd doubles as the quotient: dividend bits leave at the top as quotient bits enter at the bottom.
    always_comb begin
        rem_sh = {rem[31:0], dvd[31]};
        diff   = rem_sh - {1'b0, dvs};
        q_bit  = ~diff[32];
    end

    always_comb begin
        fix_result = 32'd0;
        if (div0)
            fix_result = op_r[1] ? dvd : 32'hFFFF_FFFF;
        else if (ovf)
            fix_result = op_r[1] ? 32'd0 : 32'h8000_0000;
        else if (op_r[1])
            fix_result = neg_r ? (32'd0 - rem[31:0]) : rem[31:0];
        else
            fix_result = neg_q ? (32'd0 - dvd) : dvd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!stall_in) begin
            case (state)
                IDLE:    if (accept) state_nxt = in_special ? FIXUP : CALC;
                CALC:    if (cnt == 5'd0) state_nxt = FIXUP;
                FIXUP:   state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= 5'd0;
            op_r       <= 2'd0;
            dvd        <= 32'd0;
            dvs        <= 32'd0;
            rem        <= 33'd0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            div0       <= 1'b0;
            ovf        <= 1'b0;
            result_out <= 32'd0;
        end else if (!stall_in) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_r  <= op_in;
                        div0  <= in_div0;
                        ovf   <= in_ovf;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        cnt   <= in_special ? 5'd0 : 5'd31;
                        // Special cases keep raw rs1 so REM/REMU by zero can return it untouched.
                        dvd   <= in_special ? rs1_value_in : a_mag;
                        dvs   <= b_mag;
                        rem   <= 33'd0;
                    end
                end
                CALC: begin
                    rem <= q_bit ? diff : rem_sh;
                    dvd <= {dvd[30:0], q_bit};
                    cnt <= cnt - 5'd1;
                end
                FIXUP: result_out <= fix_result;
                default: ;
            endcase
        end
    end

    assign busy_out = (state != IDLE);
    assign done_out = (state == DONE);

endmodule

// File: tb/tb_rv32_div.sv
// Self-checking bench for rv32_div: directed RV32M cases, random operands against an arithmetic model,
// stall, back-to-back and mid-operation reset scenarios.
module tb_rv32_div;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_in;
    logic        start_in;
    logic [1:0]  op_in;
    logic [31:0] rs1_value_in;
    logic [31:0] rs2_value_in;
    logic        busy_out;
    logic        done_out;
    logic [31:0] result_out;

    int total = 0;
    int bad   = 0;

    rv32_div dut (
        .clk          (clk),
        .reset        (reset),
        .stall_in     (stall_in),
        .start_in     (start_in),
        .op_in        (op_in),
        .rs1_value_in (rs1_value_in),
        .rs2_value_in (rs2_value_in),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .result_out   (result_out)
    );

    always #5 clk = ~clk;

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            2'd0:    return sa / sb;
            2'd1:    return a / b;
            2'd2:    return sa % sb;
            default: return a % b;
        endcase
    endfunction

    // Waits for IDLE, issues one op, scrambles inputs after acceptance, and checks busy, latency, result.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
        logic [31:0] exp;
        int          exp_lat;
        int          lat;
        bit          seen;
        bit          busy_drop;
        exp       = model(op, a, b);
        exp_lat   = is_special(op, a, b) ? 1 : 33;
        seen      = 0;
        busy_drop = 0;
        lat       = 0;
        @(negedge clk);
        for (int i = 0; i < 100 && busy_out; i++) @(negedge clk);
        start_in     = 1'b1;
        op_in        = op;
        rs1_value_in = a;
        rs2_value_in = b;
        @(posedge clk);
        #1;
        start_in     = 1'b0;
        op_in        = 2'($urandom);
        rs1_value_in = $urandom;
        rs2_value_in = $urandom;
        if (busy_out !== 1'b1) busy_drop = 1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (done_out === 1'b1) begin
                lat  = n;
                seen = 1;
                break;
            end
            if (busy_out !== 1'b1) busy_drop = 1;
        end
        total++;
        if (busy_drop) begin
            bad++;
            $display("FAIL %s busy: busy_out dropped before done, want high through E0..done", name);
        end
        total++;
        if (!seen || lat != exp_lat) begin
            bad++;
            $display("FAIL %s latency: got %0d (seen=%0d) want %0d", name, lat, seen, exp_lat);
        end
        total++;
        if (result_out !== exp) begin
            bad++;
            $display("FAIL %s result: got %h want %h (op=%0d a=%h b=%h)", name, result_out, exp, op, a, b);
        end
    endtask

    task automatic test_reset();
        total++;
        if (busy_out !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy_out); end
        total++;
        if (done_out !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", done_out); end
        total++;
        if (result_out !== 32'd0) begin bad++; $display("FAIL reset result: got %h want 00000000", result_out); end
    endtask

    task automatic test_directed();
        run_op(2'd1, 32'd100, 32'd7, "divu_100_7");
        run_op(2'd3, 32'd100, 32'd7, "remu_100_7");
        run_op(2'd0, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        run_op(2'd1, 32'd5, 32'd0, "divu_by0");
        run_op(2'd3, 32'd5, 32'd0, "remu_by0");
        run_op(2'd0, 32'd5, 32'd0, "div_by0");
        run_op(2'd2, 32'hFFFF_FFF0, 32'd0, "rem_by0");
        run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        run_op(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, "divu_big");
        run_op(2'd0, 32'h8000_0000, 32'd1, "div_min_1");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: b = 32'd0 - $urandom_range(1, 15);
                default: ;
            endcase
            run_op(op, a, b, "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prev;
        run_op(2'd1, 32'd1000, 32'd10, "b2b_first");
        prev = result_out;
        @(negedge clk);
        total++;
        if (done_out !== 1'b1) begin bad++; $display("FAIL b2b done_pulse: got %b want 1", done_out); end
        @(negedge clk);
        total++;
        if (busy_out !== 1'b0 || result_out !== prev) begin
            bad++;
            $display("FAIL b2b idle_hold: busy=%b result=%h want busy=0 result=%h", busy_out, result_out, prev);
        end
        run_op(2'd3, 32'd1001, 32'd10, "b2b_second");
    endtask

    task automatic test_stall();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [31:0] held;
        int          lat;
        bit          seen;
        bit          busy_drop;
        a = $urandom;
        b = $urandom_range(1, 1000);
        exp = a / b;
        seen = 0;
        lat = 0;
        busy_drop = 0;
        @(negedge clk);
        for (int i = 0; i < 100 && busy_out; i++) @(negedge clk);
        // A start while stalled in IDLE must be ignored.
        stall_in = 1'b1;
        start_in = 1'b1;
        op_in = 2'd1;
        rs1_value_in = a;
        rs2_value_in = b;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy_out !== 1'b0) begin bad++; $display("FAIL stall idle_start: busy got %b want 0", busy_out); end
        @(negedge clk);
        stall_in = 1'b0;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        rs1_value_in = $urandom;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (done_out === 1'b1) begin
                lat = n;
                seen = 1;
                break;
            end
            if (busy_out !== 1'b1) busy_drop = 1;
            if (n == 10) stall_in = 1'b1;
            if (n == 15) stall_in = 1'b0;
        end
        total++;
        if (busy_drop) begin bad++; $display("FAIL stall busy: busy_out dropped during stalled calc"); end
        total++;
        if (!seen || lat != 38) begin bad++; $display("FAIL stall latency: got %0d (seen=%0d) want 38", lat, seen); end
        total++;
        if (result_out !== exp) begin bad++; $display("FAIL stall result: got %h want %h", result_out, exp); end
        held = result_out;
        stall_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (done_out !== 1'b1 || result_out !== held) begin
                bad++;
                $display("FAIL stall done_hold: done=%b result=%h want done=1 result=%h", done_out, result_out, held);
            end
        end
        stall_in = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (done_out !== 1'b0 || busy_out !== 1'b0) begin
            bad++;
            $display("FAIL stall done_release: done=%b busy=%b want 0 0", done_out, busy_out);
        end
    endtask

    task automatic test_reset_mid();
        bit pulse;
        pulse = 0;
        @(negedge clk);
        for (int i = 0; i < 100 && busy_out; i++) @(negedge clk);
        start_in = 1'b1;
        op_in = 2'd1;
        rs1_value_in = 32'hDEAD_BEEF;
        rs2_value_in = 32'd3;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (busy_out !== 1'b0 || done_out !== 1'b0 || result_out !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid async: busy=%b done=%b result=%h want 0 0 00000000", busy_out, done_out, result_out);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            #1;
            if (done_out !== 1'b0) pulse = 1;
        end
        total++;
        if (pulse) begin bad++; $display("FAIL reset_mid no_done: got done pulse after reset, want none"); end
        run_op(2'd1, 32'd9, 32'd3, "reset_mid_divu_9_3");
    endtask

    initial begin
        reset = 1'b1;
        stall_in = 1'b0;
        start_in = 1'b0;
        op_in = 2'd0;
        rs1_value_in = 32'd0;
        rs2_value_in = 32'd0;
        #1;
        test_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_directed();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
